// File: rtl/eth_header_parser.sv
// eth_header_parser: streaming L2 header parser (MACs, VLAN/QinQ, EtherType)
// with frame byte accounting, runt and abort detection.
module eth_header_parser #(
  parameter int DATA_W   = 128,
  parameter int VLAN_EN  = 1,
  parameter int MAX_TAGS = 2,
  localparam int NB  = DATA_W / 8,
  localparam int BCW = $clog2(NB) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_ebp,
  input  logic [BCW-1:0]    i_byte_cnt,
  output logic              o_hdr_valid,
  output logic [47:0]       o_mac_destination,
  output logic [47:0]       o_mac_source,
  output logic [15:0]       o_ether_type,
  output logic [1:0]        o_vlan_cnt,
  output logic [11:0]       o_vlan_outer_vid,
  output logic [11:0]       o_vlan_inner_vid,
  output logic [4:0]        o_payload_offset,
  output logic              o_len_valid,
  output logic [15:0]       o_frame_len,
  output logic              o_frame_err,
  output logic              o_runt,
  output logic              o_abort
);

  localparam int HB = 22;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  state_e              state_q;
  logic [HB-1:0][7:0]  buf_q, buf_d;
  logic [4:0]          cap_q, cap_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [16:0]         sum;
  logic                hproc, abort, complete, runt;
  logic                tag1, tag2;
  logic [1:0]          tags;
  logic [15:0]         et_d;
  logic [11:0]         ov_d, iv_d;

  logic                hdr_valid_q, len_valid_q, runt_q, abort_q;
  logic [47:0]         dst_q, src_q;
  logic [15:0]         et_q, len_q;
  logic [1:0]          vcnt_q;
  logic [11:0]         ov_q, iv_q;
  logic [4:0]          off_q;
  logic                err_q;

  // Beat decode: header byte placement, byte count and tag parse
  always_comb begin
    int base, nb, k, c;
    hproc = i_valid && (i_sop || state_q == HDR);
    abort = i_valid && i_sop && state_q != IDLE;
    base  = i_sop ? 0 : int'(cap_q);
    nb    = i_eop ? int'(i_byte_cnt) : NB;
    buf_d = i_sop ? '0 : buf_q;
    for (int i = 0; i < HB; i++) begin
      k = i - base;
      if (hproc && k >= 0 && k < nb && k < NB)
        buf_d[i] = 8'(i_data >> (DATA_W - 8 * (k + 1)));
    end
    c = base + nb;
    if (c > HB) c = HB;
    cap_d    = hproc ? 5'(c) : cap_q;
    complete = hproc && (c == HB || i_eop);

    sum   = {1'b0, (i_sop ? 16'd0 : cnt_q)} + 17'(nb);
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];

    tag1 = (VLAN_EN != 0) &&
           ({buf_d[12], buf_d[13]} == 16'h8100 ||
            {buf_d[12], buf_d[13]} == 16'h88A8);
    tag2 = tag1 && (MAX_TAGS == 2) &&
           {buf_d[16], buf_d[17]} == 16'h8100;
    tags = {1'b0, tag1} + {1'b0, tag2};
    runt = c < 14 + 4 * int'(tags);
    et_d = tag2 ? {buf_d[20], buf_d[21]} :
           tag1 ? {buf_d[16], buf_d[17]} :
                  {buf_d[12], buf_d[13]};
    ov_d = tag1 ? {buf_d[14][3:0], buf_d[15]} : 12'h000;
    iv_d = tag2 ? {buf_d[18][3:0], buf_d[19]} : 12'h000;
  end

  // Frame FSM, header capture and registered result strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      hdr_valid_q <= 1'b0;
      len_valid_q <= 1'b0;
      runt_q      <= 1'b0;
      abort_q     <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      et_q        <= '0;
      vcnt_q      <= '0;
      ov_q        <= '0;
      iv_q        <= '0;
      off_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      hdr_valid_q <= 1'b0;
      len_valid_q <= 1'b0;
      runt_q      <= 1'b0;
      abort_q     <= 1'b0;
      if (i_valid && (i_sop || state_q != IDLE)) begin
        buf_q <= buf_d;
        cap_q <= cap_d;
        cnt_q <= cnt_d;
        if (complete && runt)
          runt_q <= 1'b1;
        if (complete && !runt) begin
          hdr_valid_q <= 1'b1;
          dst_q  <= {buf_d[0], buf_d[1], buf_d[2],
                     buf_d[3], buf_d[4], buf_d[5]};
          src_q  <= {buf_d[6], buf_d[7], buf_d[8],
                     buf_d[9], buf_d[10], buf_d[11]};
          et_q   <= et_d;
          vcnt_q <= tags;
          ov_q   <= ov_d;
          iv_q   <= iv_d;
          off_q  <= 5'd14 + {1'b0, tags, 2'b00};
        end
        // A sop inside a frame closes the old one with its
        // truncated length; the new frame carries on this beat.
        if (abort) begin
          abort_q     <= 1'b1;
          len_valid_q <= 1'b1;
          len_q       <= cnt_q;
          err_q       <= 1'b1;
        end else if (i_eop) begin
          len_valid_q <= 1'b1;
          len_q       <= cnt_d;
          err_q       <= i_ebp | (complete & runt);
        end
        if (i_eop)
          state_q <= IDLE;
        else if (hproc && !complete)
          state_q <= HDR;
        else
          state_q <= BODY;
      end
    end
  end

  assign o_hdr_valid       = hdr_valid_q;
  assign o_mac_destination = dst_q;
  assign o_mac_source      = src_q;
  assign o_ether_type      = et_q;
  assign o_vlan_cnt        = vcnt_q;
  assign o_vlan_outer_vid  = ov_q;
  assign o_vlan_inner_vid  = iv_q;
  assign o_payload_offset  = off_q;
  assign o_len_valid       = len_valid_q;
  assign o_frame_len       = len_q;
  assign o_frame_err       = err_q;
  assign o_runt            = runt_q;
  assign o_abort           = abort_q;

endmodule

// File: doc/eth_header_parser.md
ETH_HEADER_PARSER -- requirements
Module: eth_header_parser

Interface
REQ-001 Parameter DATA_W, default 128, MAC bus width in bits; legal values 64, 128, 256.
REQ-002 Parameter VLAN_EN, default 1; 0 disables tag parsing (every frame treated as untagged).
REQ-003 Parameter MAX_TAGS, default 2; legal 1 or 2; maximum stacked VLAN tags parsed.
REQ-004 Reset RST, synchronous, active-high; clock CLK.
REQ-005 CLK  input  1  clock; all logic rising-edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  beat valid; no backpressure.
REQ-008 i_data  input  DATA_W  beat data; byte 0 of beat at [DATA_W-1 -: 8].
REQ-009 i_sop, i_eop  input  1 each  first / last beat of frame; both may be set on one beat.
REQ-010 i_ebp  input  1  frame errored, sampled on eop beat only.
REQ-011 i_byte_cnt  input  $clog2(DATA_W/8)+1  valid bytes on eop beat (1..DATA_W/8); ignored on non-eop beats (full beat).
REQ-012 o_hdr_valid  output  1  one-cycle strobe, header fields updated.
REQ-013 o_mac_destination, o_mac_source  output  48 each  frame bytes 0-5, 6-11.
REQ-014 o_ether_type  output  16  EtherType following last parsed tag.
REQ-015 o_vlan_cnt  output  2  tags parsed (0..MAX_TAGS).
REQ-016 o_vlan_outer_vid, o_vlan_inner_vid  output  12 each  VID of tag 1 / tag 2; 0 when absent.
REQ-017 o_payload_offset  output  5  14 + 4*o_vlan_cnt.
REQ-018 o_len_valid  output  1  one-cycle strobe, frame complete.
REQ-019 o_frame_len  output  16  frame byte count, saturating at 0xFFFF.
REQ-020 o_frame_err  output  1  qualified by o_len_valid: i_ebp, runt, or abort.
REQ-021 o_runt, o_abort  output  1 each  one-cycle strobes.

Function
REQ-022 FSM states IDLE, HDR, BODY; beats with i_valid=0 change no state, counter or buffer.
REQ-023 i_sop (any state) clears byte counter and 22-byte header buffer and enters HDR processing with that beat.
REQ-024 In HDR, header bytes 0..21 captured from successive beats by absolute byte offset; bytes beyond valid count ignored.
REQ-025 Header complete when 22 bytes captured, or on eop beat if earlier; FSM then moves to BODY (or IDLE if eop).
REQ-026 Parse at completion: tag1 if VLAN_EN and bytes 12-13 = 0x8100 or 0x88A8; tag2 if tag1, MAX_TAGS=2 and bytes 16-17 = 0x8100; EtherType at 12+4*tags.
REQ-027 Required length = 14+4*tags; captured bytes < required -> o_runt strobe, no o_hdr_valid, header outputs unchanged.
REQ-028 Otherwise o_hdr_valid strobes exactly one cycle after completing beat; header outputs registered, held until next o_hdr_valid.
REQ-029 Latency from sop for full frames: 1 cycle (DATA_W=256), 2 (128), 3 (64).
REQ-030 Byte counter adds DATA_W/8 per non-eop beat, i_byte_cnt on eop beat, 16-bit saturating.
REQ-031 o_len_valid strobes one cycle after eop beat with o_frame_len = total bytes, o_frame_err = i_ebp OR runt.
REQ-032 i_sop in HDR/BODY (missing eop): o_abort strobe, o_len_valid with o_frame_err=1 and truncated length, new frame starts same beat.
REQ-033 Beats in IDLE without i_sop ignored, no strobes.
REQ-034 sop+eop on one beat: single-beat frame, both strobes (or o_runt) one cycle later.

Reset
REQ-035 RST returns FSM to IDLE, clears counter, buffer and all outputs to 0 on next edge; a frame in progress is discarded with no strobe.
REQ-036 First sop after reset deassertion is processed normally.

Verification
REQ-037 DATA_W=128, 64-byte untagged frame, dst 0x001122334455, src 0x66778899AABB, type 0x0800 -> o_hdr_valid 2 cycles after sop, fields match, vlan_cnt 0, offset 14; o_len_valid len 64 err 0.
REQ-038 Double tag 0x88A8 VID 0x064 / 0x8100 VID 0x0C8, type 0x86DD -> vlan_cnt 2, outer 0x064, inner 0x0C8, type 0x86DD, offset 22; with MAX_TAGS=1 -> cnt 1, type 0x8100, offset 18.
REQ-039 Single-beat 12-byte frame (sop+eop, byte_cnt 12) -> o_runt, no o_hdr_valid, o_len_valid len 12 err 1.
REQ-040 sop mid-BODY after 48 bytes -> o_abort and o_len_valid len 48 err 1 same cycle; new frame parsed correctly.
REQ-041 Idle gaps (i_valid=0) between every beat, DATA_W=64 -> identical outputs to gapless run; i_ebp=1 on eop -> err 1.
REQ-042 RST asserted mid-HDR -> all outputs 0, no strobes; next frame parses correctly.
